mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide responder for the multicycle MIPS datapath: it is the slave end of the controller's `div_mult_ctrl` / `div_zero` interface. It accepts a command from the control FSM, and runs a 32-iteration shift-add multiply or restoring divide on 32-bit operands. It writes the 64-bit result into the HI/LO registers and reports completion and divide-by-zero back to the controller.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI/LO are each `WIDTH` bits.
- `ITER_W`, 6: iteration counter width. Must satisfy 2^ITER_W > WIDTH.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `div_mult_ctrl`, input, 2: command. 00 = none, 01 = multiply, 10 = divide, 11 = reserved (ignored).
- `unsignedn`, input, 1: 1 = unsigned operation, 0 = signed two's complement. Sampled at accept.
- `a`, input, WIDTH: multiplicand or dividend. Sampled at accept.
- `b`, input, WIDTH: multiplier or divisor. Sampled at accept.
- `hi`, output, WIDTH: product upper half, or divide remainder.
- `lo`, output, WIDTH: product lower half, or divide quotient.
- `busy`, output, 1: high from the accept edge until the DONE state is entered.
- `done`, output, 1: single-cycle completion pulse.
- `div_zero`, output, 1: sticky divide-by-zero flag.

## Operation
- **States:** IDLE, MULT, DIV, FIX, DONE, HOLD.
- **Accept:** a command is accepted only in IDLE with `div_mult_ctrl` equal to 01 or 10.
  - At the accept edge the unit latches the operand magnitudes (absolute values when signed), the result sign, the dividend sign and the opcode.
  - It clears the counter and `div_zero`, and enters MULT or DIV.
  - Code 11 in IDLE: no effect.
- **MULT:** 64-bit accumulator, one bit per cycle. If the multiplier LSB is 1, add the multiplicand to the upper half, then shift right by one with carry-in.
- **DIV:** restoring division, one quotient bit per cycle.
  - Shift the {remainder, dividend} pair left by one.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1.
- **Iteration count:** after exactly WIDTH iterations (counter reaches WIDTH-1), go to FIX.
- **FIX:** apply signs and load `hi`/`lo` on this edge.
  - Multiply, signed, operand signs differ: negate the 64-bit product.
  - Divide, signed: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
  - Unsigned: no correction.
  - Then go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to HOLD.
- **HOLD:** wait for `div_mult_ctrl`==00, then go to IDLE. A command held high therefore never restarts the unit.
- **Divide by zero:**
  - `b`==0 with a divide command at accept: set `div_zero`=1 and go directly to DONE.
  - `hi`/`lo` are unchanged.
  - `div_zero` stays 1 until the next accepted command.
- **Signed overflow:** −2^31 / −1 gives `lo`=0x80000000, `hi`=0. This is the natural result of the magnitude algorithm; no flag is raised.
- **Result hold:** `hi`/`lo` change only in FIX or on reset. They hold their value in every other state.
- **Commands while busy:** changes to `div_mult_ctrl`, `a` or `b` while busy are ignored.

## Timing
- **Reset** (`reset`==0 at a rising edge): state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, counter=0. Reset overrides everything, including mid-operation: the computation is aborted and the result is discarded.
- **Normal latency:** accept edge E0 → iterations on E1..E32 → FIX on E33. `hi`/`lo` are valid from E33 onward.
- **done:** high during the cycle after E33 (E33..E34). `busy` is high from E0 until E33 and low from E33.
- **Divide by zero:** accept edge E0 → DONE. `done` and `div_zero` are high in the cycle after E0, and `busy` never rises.
- **Back-to-back commands:** the next command can be accepted on the edge after `div_mult_ctrl` is observed at 00 in HOLD, so at minimum E36 for a controller that drops the command in the DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Signed multiply:** mult, `unsignedn`=0, a=7, b=0xFFFFFFFD (−3) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. `done` pulses exactly 33 cycles after accept and lasts 1 cycle. `busy` is high for 33 cycles.
- **Unsigned multiply:** mult, `unsignedn`=1, a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. With `unsignedn`=0 and the same operands → `hi`=0, `lo`=1.
- **Signed divide:** div, `unsignedn`=0, a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** preload `hi`=0x12, `lo`=0x34 with a prior operation, then div with b=0 → `div_zero`=1 and `done`=1 one cycle after accept; `hi`/`lo` unchanged. A following mult 2×3 clears `div_zero` at accept and gives `lo`=6.
- **Held command:** hold `div_mult_ctrl`=01 for 50 cycles → exactly one `done` pulse and no restart. Drop to 00 and then apply 11 → nothing accepted, `busy` stays 0.
- **Reset mid-operation:** pull `reset` low at iteration 10 of a multiply → next edge gives all outputs 0 and state IDLE. A new divide 100/7 after release → `lo`=14, `hi`=2.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle multiply/divide slave for the multicycle MIPS datapath. The
// control FSM issues a command on div_mult_ctrl. The unit runs a WIDTH-step
// shift-add multiply or a restoring divide on operand magnitudes. It then
// applies the result signs and loads the 64-bit result into HI/LO.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   div_mult_ctrl  command: 00 none, 01 multiply, 10 divide, 11 ignored
//   unsignedn      1 = unsigned operation, 0 = signed (sampled at accept)
//   a, b           multiplicand/dividend and multiplier/divisor (sampled at accept)
//   hi, lo         product upper/lower half, or remainder/quotient
//   busy           high from the accept edge until DONE is entered
//   done           one-cycle completion pulse
//   div_zero       sticky divide-by-zero flag, cleared by the next accepted command
//
// ITER_W must satisfy 2**ITER_W > WIDTH so that the iteration counter can
// reach WIDTH-1.
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       div_mult_ctrl,
  input  logic             unsignedn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  // FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_MULT = 2'b01;
  localparam logic [1:0] CMD_DIV  = 2'b10;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]         state;
  logic [ITER_W-1:0]  iter_cnt;

  // Shared working register.
  //   multiply: {partial product upper, multiplier / product lower}
  //   divide:   {partial remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0] acc;
  // Multiplicand (multiply) or divisor (divide) magnitude
  logic [WIDTH-1:0]   opnd;
  logic               op_div;   // latched opcode: 1 = divide
  logic               neg_res;  // negate product / quotient in FIX
  logic               neg_rem;  // negate remainder in FIX (dividend sign)

  // ---------------------------------------------------------------------------
  // Accept decode and operand magnitudes
  // ---------------------------------------------------------------------------
  logic             is_mult_cmd;
  logic             is_div_cmd;
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_mult_cmd = (div_mult_ctrl == CMD_MULT);
  assign is_div_cmd  = (div_mult_ctrl == CMD_DIV);
  assign accept      = (state == S_IDLE) && (is_mult_cmd || is_div_cmd);

  assign a_neg = ~unsignedn & a[WIDTH-1];
  assign b_neg = ~unsignedn & b[WIDTH-1];
  // The most negative value maps to 2**(WIDTH-1), which is still correct
  // when the WIDTH-bit magnitude is treated as unsigned.
  assign a_mag = a_neg ? (-a) : a;
  assign b_mag = b_neg ? (-b) : b;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // Multiply step: conditionally add the multiplicand to the upper half. Then
  // shift the whole accumulator right, and the add carry enters at the top.
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_next;

  assign mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mult_next = {mult_sum, acc[WIDTH-1:1]};

  // Divide step: shift {remainder, dividend} left by one, then trial-subtract
  // the divisor from the WIDTH+1-bit shifted remainder. If it fits, the quotient
  // bit shifted into the LSB is 1. A kept difference is always below the
  // divisor, so its low WIDTH bits are exact.
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_fits  = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign div_next  = {(div_fits ? div_diff : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_fits};

  // ---------------------------------------------------------------------------
  // Sign correction applied in FIX
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (op_div) begin
      if (neg_res) fix_lo = -acc[WIDTH-1:0];
      if (neg_rem) fix_hi = -acc[2*WIDTH-1:WIDTH];
    end else if (neg_res) begin
      {fix_hi, fix_lo} = -acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Working registers (no reset)
  // ---------------------------------------------------------------------------
  // NOTE: these registers are loaded at every accept before they are read.
  // Resetting them would only add reset fan-out, and the control FSM below
  // discards their contents on reset anyway.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div  <= is_div_cmd;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (is_div_cmd) begin
        acc  <= {{WIDTH{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{WIDTH{1'b0}}, b_mag};
        opnd <= a_mag;
      end
    end else if (state == S_MULT) begin
      acc <= mult_next;
    end else if (state == S_DIV) begin
      acc <= div_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            iter_cnt <= '0;
            div_zero <= 1'b0;
            if (is_div_cmd && (b == '0)) begin
              // Divide by zero skips straight to DONE; busy never rises and
              // HI/LO keep their previous value.
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= is_div_cmd ? S_DIV : S_MULT;
            end
          end
        end

        S_MULT, S_DIV: begin
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == LAST_ITER) state <= S_FIX;
        end

        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end

        S_DONE: state <= S_HOLD;

        // A command still held from the last operation must be released
        // before the unit can accept a new one.
        S_HOLD: if (div_mult_ctrl == CMD_NONE) state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit. Directed vectors come from a table.
// Randomized operations are compared against an arithmetic reference model,
// and short hand-written sequences cover the held command, reserved code and
// mid-operation reset cases.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   div_mult_ctrl;
  logic         unsignedn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  mult_div_unit #(.WIDTH(W), .ITER_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .div_mult_ctrl (div_mult_ctrl),
    .unsignedn     (unsignedn),
    .a             (a),
    .b             (b),
    .hi            (hi),
    .lo            (lo),
    .busy          (busy),
    .done          (done),
    .div_zero      (div_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain 64-bit arithmetic on the architectural values.
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic model_op(input logic [1:0] cmd, input logic un,
                          input logic [W-1:0] av, input logic [W-1:0] bv);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (cmd == 2'b10 && bv == '0) begin
      m_dz = 1'b1;                 // result registers untouched
    end else if (cmd == 2'b01) begin
      m_dz = 1'b0;
      if (un) p = {32'b0, av} * {32'b0, bv};
      else    p = sa * sb;
      {m_hi, m_lo} = p;
    end else begin
      m_dz = 1'b0;
      if (un) begin
        m_lo = av / bv;
        m_hi = av % bv;
      end else begin
        m_lo = 32'(sa / sb);       // truncates toward zero
        m_hi = 32'(sa % sb);       // remainder has the dividend's sign
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // One full command: accept, wait for done, release, check everything.
  // Latency is the number of edges from the accept edge to the edge after
  // which done is first seen.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [1:0] cmd, input logic un,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit use_model,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
    int           lat;
    int           busy_cnt;
    int           elat;
    bit           held_ok;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;
    prev_hi = m_hi;
    prev_lo = m_lo;
    model_op(cmd, un, av, bv);
    if (use_model) begin
      eh  = m_hi;
      el  = m_lo;
      edz = m_dz;
    end
    elat = edz ? 0 : 33;

    div_mult_ctrl = cmd;
    unsignedn     = un;
    a             = av;
    b             = bv;
    @(posedge clk); #1;            // accept edge E0
    check({name, " div_zero_at_accept"}, 64'(div_zero), 64'(edz));

    lat      = 0;
    busy_cnt = 0;
    held_ok  = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (hi !== prev_hi || lo !== prev_lo) held_ok = 1'b0;
      a = $urandom;                // operand changes while busy are ignored
      b = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"},      64'(lat), 64'(elat));
    check({name, " busy_cycles"},  64'(busy_cnt), 64'(elat));
    check({name, " busy_at_done"}, 64'(busy), 64'd0);
    check({name, " result_held"},  64'(held_ok), 64'd1);
    check({name, " hi"},           64'(hi), 64'(eh));
    check({name, " lo"},           64'(lo), 64'(el));
    check({name, " div_zero"},     64'(div_zero), 64'(edz));

    div_mult_ctrl = 2'b00;         // controller drops the command in DONE
    @(posedge clk); #1;
    check({name, " done_width"}, 64'(done), 64'd0);
    @(posedge clk); #1;            // HOLD sees 00, back to IDLE
  endtask

  typedef struct {
    string        name;
    logic [1:0]   cmd;
    logic         un;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [1:0] c, input logic u,
                              input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] h, input logic [W-1:0] l, input logic z);
    vec_t v;
    v.name = n; v.cmd = c; v.un = u; v.a = av; v.b = bv; v.hi = h; v.lo = l; v.dz = z;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    int busy_cnt;
    logic [1:0]   rc;
    logic         ru;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs.push_back(mk("smul_7_m3",   2'b01, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0));
    vecs.push_back(mk("umul_max",    2'b01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0));
    vecs.push_back(mk("smul_m1_m1",  2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0));
    vecs.push_back(mk("sdiv_m7_2",   2'b10, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0));
    vecs.push_back(mk("sdiv_ovf",    2'b10, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0));
    vecs.push_back(mk("udiv_preload",2'b10, 1'b1, 32'h00003412, 32'h00000100, 32'h00000012, 32'h00000034, 1'b0));
    vecs.push_back(mk("div_by_zero", 2'b10, 1'b0, 32'h00000055, 32'h00000000, 32'h00000012, 32'h00000034, 1'b1));
    vecs.push_back(mk("mul_2_3",     2'b01, 1'b0, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 1'b0));

    // Reset state
    reset = 1'b0; div_mult_ctrl = 2'b00; unsignedn = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi",       64'(hi), 64'd0);
    check("reset lo",       64'(lo), 64'd0);
    check("reset busy",     64'(busy), 64'd0);
    check("reset done",     64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].cmd, vecs[i].un, vecs[i].a, vecs[i].b, 1'b0,
             vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // Held command: one completion only, no restart
    model_op(2'b01, 1'b1, 32'd5, 32'd6);
    div_mult_ctrl = 2'b01; unsignedn = 1'b1; a = 32'd5; b = 32'd6;
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("held done_pulses", 64'(done_cnt), 64'd1);
    check("held busy_after",  64'(busy), 64'd0);
    check("held lo",          64'(lo), 64'(m_lo));

    // Reserved code 11 is never accepted
    div_mult_ctrl = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    div_mult_ctrl = 2'b11;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("code11 busy_cycles", 64'(busy_cnt), 64'd0);
    check("code11 done_pulses", 64'(done_cnt), 64'd0);
    check("code11 lo_kept",     64'(lo), 64'(m_lo));
    div_mult_ctrl = 2'b00;
    @(posedge clk); #1;

    // Reset at iteration 10 of a multiply
    div_mult_ctrl = 2'b01; unsignedn = 1'b0; a = 32'd9; b = 32'd11;
    @(posedge clk); #1;            // E0
    repeat (9) begin
      @(posedge clk); #1;          // E1..E9
    end
    reset = 1'b0;
    div_mult_ctrl = 2'b00;
    @(posedge clk); #1;            // E10 with reset low
    check("midreset hi",       64'(hi), 64'd0);
    check("midreset lo",       64'(lo), 64'd0);
    check("midreset busy",     64'(busy), 64'd0);
    check("midreset done",     64'(done), 64'd0);
    check("midreset div_zero", 64'(div_zero), 64'd0);
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("postreset busy", 64'(busy), 64'd0);
    run_op("udiv_100_7", 2'b10, 1'b1, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      rc = 2'($urandom_range(1, 2));
      ru = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(1, 15));
      if (i % 4 == 2) rb = -32'($urandom_range(1, 15));
      if (i % 6 == 3) ra = 32'h80000000;
      if (i % 7 == 5) begin rc = 2'b10; rb = '0; end
      run_op($sformatf("rand%0d", i), rc, ru, ra, rb, 1'b1, '0, '0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
